popcount_accum: RTL and testbench
=================================

# popcount_accum

Accumulates the per-cycle 8-bit popcounts produced by the 128-input adder tree over `NUM_CHUNKS` consecutive chunks, forming one neuron's full binary dot-product count. On the last chunk it compares the total against a threshold and emits the sum and a 1-bit activation through a ready/valid output register. It sits directly downstream of the adder tree and upstream of the activation buffer. The block's `in_valid` is the adder tree's input valid, delayed by that tree's 2-cycle latency.

## Interface
- `NUM_CHUNKS`, default 8: 128-bit chunks per neuron; legal range ≥ 1.
- `CNT_W`, default 8: width of the incoming popcount.
- `ACC_W`, default 11: accumulator width, equal to clog2(NUM_CHUNKS*128+1).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_count` is valid this cycle.
- `in_ready` output 1: block accepts a chunk this cycle.
- `in_count` input `CNT_W`: popcount of one 128-bit chunk, 0..128.
- `thr` input `ACC_W`: activation threshold, sampled on the first chunk of each neuron.
- `out_valid` output 1: result held in the output register.
- `out_ready` input 1: consumer takes the result.
- `out_sum` output `ACC_W`: total popcount for the neuron.
- `out_act` output 1: 1 when `out_sum` ≥ sampled threshold.
- `err` output 1: sticky flag, set when an `in_count` greater than 128 was accepted.
- `out_dot` output `ACC_W+1`, signed: present only with `POPACC_DOT_EN`; see Configuration.

## Operation
- Accept: a chunk is accepted when `in_valid && in_ready`.
- Accumulator state: `acc` (`ACC_W` bits), `chunk_cnt` (0..NUM_CHUNKS-1), and `thr_q`.
- First chunk (`chunk_cnt`==0): `acc` <= clamp(`in_count`); `thr_q` <= `thr`.
- Middle chunks: `acc` <= `acc` + clamp(`in_count`); `chunk_cnt` increments.
- Clamp rule: any `in_count` > 128 is replaced by 128 and sets `err`. `err` clears only on reset.
- Last chunk (`chunk_cnt`==NUM_CHUNKS-1):
  - Load the output register with `out_sum` <= `acc` + clamp(`in_count`) and `out_act` <= (that sum ≥ `thr_q`). When NUM_CHUNKS==1, compare against `thr` directly.
  - `chunk_cnt` wraps to 0.
  - `acc` is don't-care until the next first chunk.
- Output register is separate from the accumulator. The next neuron accumulates while the previous result waits.
- Ready rule: `in_ready` = !(`out_valid` && !`out_ready` && `chunk_cnt`==NUM_CHUNKS-1). Only the last chunk stalls on a full output register.
- Output handshake: `out_valid` drops after `out_ready` while valid, unless a new last chunk loads in the same cycle; in that case `out_valid` stays 1 with the new data.
- Output stability: `out_sum`, `out_act` and `out_dot` are stable while `out_valid` && !`out_ready`.
- Arithmetic: unsigned throughout. `ACC_W` is guaranteed never to overflow, since the maximum sum is NUM_CHUNKS*128.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_act`=0, `err`=0, `out_dot`=0, `chunk_cnt`=0, `acc`=0.
- Latency: last chunk accepted at cycle k gives `out_valid`=1 at k+1.
- Throughput: one chunk per cycle with `out_ready` held high; no bubbles between neurons.
- Reset mid-neuron: partial `acc` and `chunk_cnt` are discarded. The next accepted chunk is treated as a first chunk.
- Reset with `out_valid` high: the held result is lost.

## Configuration
- `POPACC_DOT_EN` defined:
  - Adds port `out_dot` = 2*`out_sum` − NUM_CHUNKS*128, signed `ACC_W+1` bits. This is the XNOR-net ±1 dot product.
  - `out_dot` is registered with `out_sum`.
- `POPACC_DOT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `popacc_pkg` holds:
  - `CHUNK_BITS` = 128.
  - Default `CNT_W`.
  - A function computing `ACC_W` from NUM_CHUNKS.
  - The clamp constant 128.
- One natural sub-module, `popacc_out_reg`: the ready/valid output holding register carrying sum, act and dot.

## Test plan
All scenarios use NUM_CHUNKS=8.
- Reset: assert `rst_n`=0 asynchronously mid-cycle -> all outputs at their reset values immediately; `in_ready`=1.
- Pass case: 8 chunks of 64, `thr`=512, `out_ready`=1 -> one cycle after the 8th chunk: `out_sum`=512, `out_act`=1, `out_dot`=0.
- Fail case: 8 chunks of 63, `thr`=505 -> `out_sum`=504, `out_act`=0, `out_dot`=−16.
- Backpressure: `out_ready`=0 after the first result; 8 more chunks of 10 offered -> 7 accepted, `in_ready`=0 on the 8th. Raise `out_ready` -> first result taken, 8th chunk accepted the same cycle, next `out_sum`=80.
- Clamp: one chunk of 200 plus 7 chunks of 0 -> `out_sum`=128, `err`=1, and `err` stays 1 through later neurons.
- Reset mid-neuron: 3 chunks of 100, then reset, then 8 chunks of 1 -> `out_sum`=8.

Source files
------------

// File: rtl/popacc_pkg.sv
// ============================================================================
// Module : popacc_pkg
// Brief  : Shared constants and width helper for the popcount accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package popacc_pkg;

  localparam int CHUNK_BITS = 128;
  localparam int CNT_W_DEF  = 8;
  localparam int CLAMP_MAX  = 128;

  // Width that holds every sum from 0 up to num_chunks*CHUNK_BITS inclusive.
  function automatic int acc_w_calc(input int num_chunks);
    return $clog2(num_chunks * CHUNK_BITS + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/popacc_out_reg.sv
// ============================================================================
// Module : popacc_out_reg
// Brief  : Ready/valid result holding register (sum, act, optional dot).
//          Dot field present only when POPACC_DOT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module popacc_out_reg #(
  parameter int ACC_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [ACC_W-1:0]   i_sum,
  input  logic               i_act,
`ifdef POPACC_DOT_EN
  input  logic signed [ACC_W:0] i_dot,
  output logic signed [ACC_W:0] o_dot,
`endif
  input  logic               i_ready,
  output logic               o_valid,
  output logic [ACC_W-1:0]   o_sum,
  output logic               o_act
);

  logic             r_valid;
  logic [ACC_W-1:0] r_sum;
  logic             r_act;

  // A load wins over a take in the same cycle, so valid stays high with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_act   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_sum   <= i_sum;
      r_act   <= i_act;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef POPACC_DOT_EN
  logic signed [ACC_W:0] r_dot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dot <= '0;
    end else if (i_load) begin
      r_dot <= i_dot;
    end
  end

  assign o_dot = r_dot;
`endif

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_act   = r_act;

endmodule

`default_nettype wire

// File: rtl/popcount_accum.sv
// ============================================================================
// Module : popcount_accum
// Brief  : Sums NUM_CHUNKS per-chunk popcounts into one neuron count and
//          thresholds it. Optional signed dot output under POPACC_DOT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module popcount_accum
  import popacc_pkg::*;
#(
  parameter int NUM_CHUNKS = 8,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ACC_W      = acc_w_calc(NUM_CHUNKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CNT_W-1:0]      in_count,
  input  logic [ACC_W-1:0]      thr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_act,
`ifdef POPACC_DOT_EN
  output logic signed [ACC_W:0] out_dot,
`endif
  output logic                  err
);

  localparam int              c_cnt_w = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_CHUNKS - 1);

  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_thr_q;
  logic [c_cnt_w-1:0] r_chunk_cnt;
  logic               r_err;

  logic               w_accept;
  logic               w_first;
  logic               w_last;
  logic               w_over;
  logic               w_load;
  logic [ACC_W-1:0]   w_clamp;
  logic [ACC_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_thr_eff;
  logic               w_act;

  assign w_first  = (r_chunk_cnt == '0);
  assign w_last   = (r_chunk_cnt == c_last);
  assign in_ready = !(out_valid && !out_ready && w_last);
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept && w_last;

  assign w_over  = (in_count > CNT_W'(CLAMP_MAX));
  assign w_clamp = w_over ? ACC_W'(CLAMP_MAX) : ACC_W'(in_count);
  assign w_sum   = (w_first ? '0 : r_acc) + w_clamp;

  // With a single chunk the first chunk is also the last, so use live thr.
  assign w_thr_eff = w_first ? thr : r_thr_q;
  assign w_act     = (w_sum >= w_thr_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_thr_q     <= '0;
      r_chunk_cnt <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      if (w_first) begin
        r_thr_q <= thr;
      end
      if (w_last) begin
        r_chunk_cnt <= '0;
      end else begin
        r_chunk_cnt <= r_chunk_cnt + c_cnt_w'(1);
      end
      if (w_over) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;

`ifdef POPACC_DOT_EN
  // Modular subtraction in ACC_W+1 bits yields the correct two's-complement value.
  localparam logic [ACC_W:0] c_dot_off = (ACC_W + 1)'(NUM_CHUNKS * CHUNK_BITS);
  logic signed [ACC_W:0] w_dot;
  assign w_dot = {w_sum, 1'b0} - c_dot_off;
`endif

  popacc_out_reg #(
    .ACC_W (ACC_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_sum   (w_sum),
    .i_act   (w_act),
`ifdef POPACC_DOT_EN
    .i_dot   (w_dot),
    .o_dot   (out_dot),
`endif
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_sum   (out_sum),
    .o_act   (out_act)
  );

endmodule

`default_nettype wire

// File: tb/tb_popcount_accum.sv
// ============================================================================
// Module : tb_popcount_accum
// Brief  : Directed self-checking bench for popcount_accum (NUM_CHUNKS=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_popcount_accum;

  localparam int NC = 8;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_count;
  logic [AW-1:0] thr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_act;
  logic          err;
`ifdef POPACC_DOT_EN
  logic signed [AW:0] out_dot;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  popcount_accum #(
    .NUM_CHUNKS (NC),
    .CNT_W      (8),
    .ACC_W      (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .thr       (thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_act   (out_act),
`ifdef POPACC_DOT_EN
    .out_dot   (out_dot),
`endif
    .err       (err)
  );

  // Offer one chunk and return one cycle after it is accepted (bounded wait).
  task automatic feed(input logic [7:0] cnt, input logic [AW-1:0] t);
    in_valid = 1'b1;
    in_count = cnt;
    thr      = t;
    #1;
    for (int w = 0; w < 20 && !in_ready; w++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL feed_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic feed_neuron(input logic [7:0] cnt, input logic [AW-1:0] t);
    for (int i = 0; i < NC; i++) feed(cnt, (i == 0) ? t : '0);
  endtask

  task automatic test_reset;
    out_ready = 1'b0;
    feed_neuron(8'd200, 11'd0);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_sum !== 11'd1024) begin n_fail++; $display("FAIL rst_pre_sum: got %0d want 1024", out_sum); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_sum !== 11'd0) begin n_fail++; $display("FAIL rst_sum: got %0d want 0", out_sum); end
    n_cmp++; if (out_act !== 1'b0) begin n_fail++; $display("FAIL rst_act: got %0b want 0", out_act); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
`ifdef POPACC_DOT_EN
    n_cmp++; if (out_dot !== 12'sd0) begin n_fail++; $display("FAIL rst_dot: got %0d want 0", out_dot); end
`endif
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pass;
    feed_neuron(8'd64, 11'd512);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_sum !== 11'd512) begin n_fail++; $display("FAIL pass_sum: got %0d want 512", out_sum); end
    n_cmp++; if (out_act !== 1'b1) begin n_fail++; $display("FAIL pass_act: got %0b want 1", out_act); end
`ifdef POPACC_DOT_EN
    n_cmp++; if (out_dot !== 12'sd0) begin n_fail++; $display("FAIL pass_dot: got %0d want 0", out_dot); end
`endif
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_drop: got %0b want 0", out_valid); end
  endtask

  task automatic test_fail;
    feed_neuron(8'd63, 11'd505);
    in_valid = 1'b0;
    n_cmp++; if (out_sum !== 11'd504) begin n_fail++; $display("FAIL fail_sum: got %0d want 504", out_sum); end
    n_cmp++; if (out_act !== 1'b0) begin n_fail++; $display("FAIL fail_act: got %0b want 0", out_act); end
`ifdef POPACC_DOT_EN
    n_cmp++; if (out_dot !== -12'sd16) begin n_fail++; $display("FAIL fail_dot: got %0d want -16", out_dot); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    feed_neuron(8'd16, 11'd100);
    n_cmp++; if (out_sum !== 11'd128 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: sum=%0d valid=%0b want 128/1", out_sum, out_valid);
    end
    for (int i = 0; i < NC; i++) begin
      feed(8'd32, (i == 0) ? 11'd300 : 11'd0);
      if (i < NC - 1) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_mid_valid[%0d]: got %0b want 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (out_sum !== 11'd256) begin n_fail++; $display("FAIL b2b_second_sum: got %0d want 256", out_sum); end
    n_cmp++; if (out_act !== 1'b0) begin n_fail++; $display("FAIL b2b_second_act: got %0b want 0", out_act); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    feed_neuron(8'd5, 11'd10);
    out_ready = 1'b0;
    for (int i = 0; i < NC - 1; i++) feed(8'd10, (i == 0) ? 11'd50 : 11'd0);
    n_cmp++; if (out_sum !== 11'd40 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: sum=%0d valid=%0b want 40/1", out_sum, out_valid);
    end
    in_valid = 1'b1; in_count = 8'd10; thr = '0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: in_ready=%0b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0 || out_sum !== 11'd40) begin
      n_fail++; $display("FAIL bp_stall2: in_ready=%0b sum=%0d want 0/40", in_ready, out_sum);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready=%0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 11'd80) begin
      n_fail++; $display("FAIL bp_next: valid=%0b sum=%0d want 1/80", out_valid, out_sum);
    end
    n_cmp++; if (out_act !== 1'b1) begin n_fail++; $display("FAIL bp_act: got %0b want 1", out_act); end
    @(posedge clk); #1;
  endtask

  task automatic test_clamp;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL clamp_pre_err: got %0b want 0", err); end
    feed(8'd200, 11'd100);
    for (int i = 1; i < NC; i++) feed(8'd0, 11'd0);
    in_valid = 1'b0;
    n_cmp++; if (out_sum !== 11'd128) begin n_fail++; $display("FAIL clamp_sum: got %0d want 128", out_sum); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL clamp_err: got %0b want 1", err); end
    feed_neuron(8'd1, 11'd0);
    in_valid = 1'b0;
    n_cmp++; if (err !== 1'b1 || out_sum !== 11'd8) begin
      n_fail++; $display("FAIL clamp_sticky: err=%0b sum=%0d want 1/8", err, out_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) feed(8'd100, 11'd0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    feed_neuron(8'd1, 11'd5);
    in_valid = 1'b0;
    n_cmp++; if (out_sum !== 11'd8 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_sum: sum=%0d valid=%0b want 8/1", out_sum, out_valid);
    end
    n_cmp++; if (out_act !== 1'b1) begin n_fail++; $display("FAIL mid_rst_act: got %0b want 1", out_act); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_count = '0; thr = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_pass;
    test_fail;
    test_back_to_back;
    test_backpressure;
    test_clamp;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
